// File: rtl/modulo_pkg.sv
// Shared types and constants for the self-sequenced remainder/quotient unit.
package modulo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam logic ERR_DIV0 = 1'b1;

  // Counter width able to hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/modulo_sub_step.sv
// One restoring shift-subtract step: shifts in the next dividend bit and
// subtracts the divisor magnitude when the shifted remainder is large enough.
module modulo_sub_step
  import modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] div_ext;

  always_comb begin
    shifted = {r_i[WIDTH-1:0], bit_i};
    div_ext = {1'b0, divisor_i};
    q_o     = (shifted >= div_ext);
    r_o     = q_o ? (shifted - div_ext) : shifted;
  end

endmodule

// File: rtl/modulo_unit_param.sv
// Width-parametrised A mod B / A div B unit, one quotient bit per clock,
// with optional two's-complement mode and divide-by-zero flagging.
module modulo_unit_param
  import modulo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int   CW        = cnt_w(WIDTH);
  localparam logic SIGNED_OK = (SIGNED_EN != 0);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, b_abs_q, q_q, rem_q, quo_q;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   r_q, r_next;
  logic [CW-1:0]    cnt_q;
  logic             sgn_q, sign_a_q, neg_q, div0_q, err_q, q_bit;

  modulo_sub_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (r_q),
    .divisor_i (b_abs_q),
    .bit_i     (q_q[WIDTH-1]),
    .r_o       (r_next),
    .q_o       (q_bit)
  );

  // Magnitudes; MIN negates to itself, which is exactly 2^(WIDTH-1) unsigned.
  always_comb begin
    a_abs = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_abs = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Divide-by-zero still passes through FIX so results are registered in one place.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = LOAD;
      LOAD: state_next = (b_q == '0) ? FIX : ITER;
      ITER: if (cnt_q == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      b_abs_q  <= '0;
      q_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      err_q    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          a_q   <= dividend_i;
          b_q   <= divisor_i;
          sgn_q <= signed_i & SIGNED_OK;
          err_q <= 1'b0;
        end
        LOAD: begin
          q_q      <= a_abs;
          b_abs_q  <= b_abs;
          r_q      <= '0;
          cnt_q    <= CW'(WIDTH - 1);
          sign_a_q <= sgn_q & a_q[WIDTH-1];
          neg_q    <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          div0_q   <= (b_q == '0);
        end
        ITER: begin
          r_q   <= r_next;
          q_q   <= {q_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q - CW'(1);
        end
        // Truncation toward zero: remainder follows A, quotient negated on sign mismatch.
        FIX: begin
          if (div0_q) begin
            err_q <= ERR_DIV0;
            rem_q <= a_q;
            quo_q <= '1;
          end else begin
            err_q <= 1'b0;
            rem_q <= sign_a_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
            quo_q <= neg_q ? -q_q : q_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o     = (state == IDLE);
  assign valid_o     = (state == DONE);
  assign err_o       = err_q;
  assign remainder_o = rem_q;
  assign quotient_o  = quo_q;

endmodule

// File: tb/tb_modulo_unit_param.sv
// Self-checking bench: directed literal cases plus randomized ops against a
// plain-arithmetic reference, with a per-cycle compare of valid/ready/results.
module tb_modulo_unit_param;

  localparam int WIDTH    = 16;
  localparam int LAT_NORM = WIDTH + 3;
  localparam int LAT_DIV0 = 3;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             signed_i = 1'b0;
  logic [WIDTH-1:0] dividend_i = '0;
  logic [WIDTH-1:0] divisor_i = '0;
  logic             ready_o, valid_o, err_o;
  logic [WIDTH-1:0] remainder_o, quotient_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    int               due;
    logic             err;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
  } exp_t;

  exp_t             exp_q[$];
  logic             held_err = 1'b0;
  logic [WIDTH-1:0] held_rem = '0;
  logic [WIDTH-1:0] held_quo = '0;

  modulo_unit_param #(.WIDTH(WIDTH), .SIGNED_EN(1)) dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .err_o       (err_o),
    .remainder_o (remainder_o),
    .quotient_o  (quotient_o)
  );

  always #5 clk = ~clk;

  // Reference: language division truncates toward zero with remainder sign of A.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t e;
    int   sa, sb;
    e.due = 0;
    if (b == '0) begin
      e.err = 1'b1;
      e.rem = a;
      e.quo = '1;
    end else if (s) begin
      sa    = $signed(a);
      sb    = $signed(b);
      e.err = 1'b0;
      e.quo = WIDTH'(sa / sb);
      e.rem = WIDTH'(sa % sb);
    end else begin
      e.err = 1'b0;
      e.quo = a / b;
      e.rem = a % b;
    end
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accepted requests become expectations due WIDTH+3 (or 3) edges later.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst_ni && start_i && ready_o) begin
      e     = model(dividend_i, divisor_i, signed_i);
      e.due = cyc + ((divisor_i == '0) ? LAT_DIV0 : LAT_NORM) - 1;
      exp_q.push_back(e);
      held_err = 1'b0;
    end
  end

  always @(negedge rst_ni) begin
    exp_q.delete();
    held_err = 1'b0;
    held_rem = '0;
    held_quo = '0;
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      check_output("ready", ready_o, (exp_q.size() == 0));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check_output("valid_pulse", valid_o, 1);
        check_output("err", err_o, exp_q[0].err);
        check_output("remainder", remainder_o, exp_q[0].rem);
        check_output("quotient", quotient_o, exp_q[0].quo);
        held_err = exp_q[0].err;
        held_rem = exp_q[0].rem;
        held_quo = exp_q[0].quo;
        void'(exp_q.pop_front());
      end else begin
        check_output("valid_quiet", valid_o, 0);
        check_output("err_held", err_o, held_err);
        check_output("rem_held", remainder_o, held_rem);
        check_output("quo_held", quotient_o, held_quo);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!ready_o) check_output("ready_timeout", 0, 1);
  endtask

  // One directed op: checks latency (edge that captures valid) and literal results.
  task automatic apply_stimulus(input string name, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic s,
                                input logic [WIDTH-1:0] exp_rem, input logic [WIDTH-1:0] exp_quo,
                                input logic exp_err, input int lat);
    int   m = 0;
    logic found = 1'b0;
    wait_ready();
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    @(posedge clk);
    #2;
    start_i    = 1'b0;
    dividend_i = WIDTH'($urandom);
    divisor_i  = WIDTH'($urandom);
    signed_i   = 1'($urandom);
    while (!found && m < 40) begin
      @(negedge clk);
      if (valid_o) found = 1'b1;
      else begin
        @(posedge clk);
        m++;
      end
    end
    if (!found) check_output({name, "_timeout"}, 0, 1);
    else begin
      check_output({name, "_latency"}, m + 1, lat);
      check_output({name, "_rem"}, remainder_o, exp_rem);
      check_output({name, "_quo"}, quotient_o, exp_quo);
      check_output({name, "_err"}, err_o, exp_err);
      @(negedge clk);
      check_output({name, "_one_cycle"}, valid_o, 0);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!valid_o) check_output({name, "_timeout"}, 0, 1);
  endtask

  task automatic random_ops(input int count);
    logic [WIDTH-1:0] a, b;
    int               sel;
    for (int i = 0; i < count; i++) begin
      wait_ready();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #2;
      sel = $urandom_range(0, 9);
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      case (sel)
        0: b = '0;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'hFFFF;
        3: b = a;
        4: a = WIDTH'($urandom_range(0, 20));
        default: ;
      endcase
      dividend_i = a;
      divisor_i  = b;
      signed_i   = 1'($urandom);
      start_i    = 1'b1;
      @(posedge clk);
      #2;
      start_i = 1'b0;
    end
    wait_ready();
  endtask

  initial begin
    #1;
    check_output("rst_ready", ready_o, 1);
    check_output("rst_valid", valid_o, 0);
    check_output("rst_err", err_o, 0);
    check_output("rst_rem", remainder_o, 0);
    check_output("rst_quo", quotient_o, 0);
    #20 rst_ni = 1'b1;
    @(posedge clk);
    #2;

    apply_stimulus("t1_u100m7", 16'd100, 16'd7, 1'b0, 16'd2, 16'd14, 1'b0, LAT_NORM);
    apply_stimulus("t2_sm7m3", 16'hFFF9, 16'd3, 1'b1, 16'hFFFF, 16'hFFFE, 1'b0, LAT_NORM);
    apply_stimulus("t2_s7mm3", 16'd7, 16'hFFFD, 1'b1, 16'd1, 16'hFFFE, 1'b0, LAT_NORM);
    apply_stimulus("t3_udiv0", 16'd1234, 16'd0, 1'b0, 16'd1234, 16'hFFFF, 1'b1, LAT_DIV0);
    apply_stimulus("t3_sdiv0", 16'd1234, 16'd0, 1'b1, 16'd1234, 16'hFFFF, 1'b1, LAT_DIV0);
    apply_stimulus("t4_smin", 16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000, 1'b0, LAT_NORM);
    apply_stimulus("t4_umin", 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 16'h0000, 1'b0, LAT_NORM);
    apply_stimulus("u_lt", 16'd5, 16'd9, 1'b0, 16'd5, 16'd0, 1'b0, LAT_NORM);
    apply_stimulus("u_eq", 16'd9, 16'd9, 1'b0, 16'd0, 16'd1, 1'b0, LAT_NORM);

    // start held high: operand change mid-op ignored, next op taken on first IDLE cycle.
    wait_ready();
    dividend_i = 16'd100;
    divisor_i  = 16'd7;
    signed_i   = 1'b0;
    start_i    = 1'b1;
    @(posedge clk);
    #2;
    dividend_i = 16'd50;
    divisor_i  = 16'd6;
    wait_valid("t5_op1");
    check_output("t5_op1_rem", remainder_o, 16'd2);
    check_output("t5_op1_quo", quotient_o, 16'd14);
    @(negedge clk);
    check_output("t5_first_idle", ready_o, 1);
    @(negedge clk);
    check_output("t5_back_to_back", ready_o, 0);
    start_i = 1'b0;
    wait_valid("t5_op2");
    check_output("t5_op2_rem", remainder_o, 16'd2);
    check_output("t5_op2_quo", quotient_o, 16'd8);

    // Reset in the middle of ITER.
    wait_ready();
    dividend_i = 16'd1000;
    divisor_i  = 16'd3;
    start_i    = 1'b1;
    @(posedge clk);
    #2;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    check_output("t6_ready", ready_o, 1);
    check_output("t6_valid", valid_o, 0);
    check_output("t6_err", err_o, 0);
    check_output("t6_rem", remainder_o, 0);
    check_output("t6_quo", quotient_o, 0);
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    repeat (WIDTH + 8) @(posedge clk);
    #2;

    random_ops(300);
    repeat (5) @(posedge clk);
    check_output("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
